// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared widths, opcodes and FSM state encoding for the fetch/decode sequencer
//   IW/AW/OPW       instruction, address and opcode widths
//   OP_HALT/JMP/JZ  control opcodes; all other opcodes are EXEC class
//   state_t         S_FETCH..S_HALT
package instr_fetch_unit_pkg;
  localparam int IW = 16;
  localparam int AW = 13;
  localparam int OPW = 3;
  localparam logic [OPW-1:0] OP_HALT = 3'b000;
  localparam logic [OPW-1:0] OP_JMP = 3'b001;
  localparam logic [OPW-1:0] OP_JZ = 3'b010;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_STEP, S_HALT} state_t;
  function automatic logic [OPW-1:0] opcode_of(input logic [IW-1:0] ir);
    return ir[IW-1 -: OPW];
  endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: bus between the fetch unit and its memory, program counter and datapath
//   memory:   MEM_REQ/MEM_ADDR out, MEM_RDATA/MEM_ACK in
//   counter:  PC_ADDR in, IR_ADDR/LOAD/PC_STEP out
//   datapath: ZERO/EXEC_DONE in, EXEC_VALID/IR_OUT out
//   status:   HALTED out
// master = fetch unit side, slave = environment side
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;
  logic [AW-1:0] PC_ADDR;
  logic MEM_REQ;
  logic [AW-1:0] MEM_ADDR;
  logic [IW-1:0] MEM_RDATA;
  logic MEM_ACK;
  logic ZERO;
  logic [AW-1:0] IR_ADDR;
  logic LOAD;
  logic PC_STEP;
  logic [IW-1:0] IR_OUT;
  logic EXEC_VALID;
  logic EXEC_DONE;
  logic HALTED;
  modport master (
    input PC_ADDR, MEM_RDATA, MEM_ACK, ZERO, EXEC_DONE,
    output MEM_REQ, MEM_ADDR, IR_ADDR, LOAD, PC_STEP, IR_OUT, EXEC_VALID, HALTED
  );
  modport slave (
    output PC_ADDR, MEM_RDATA, MEM_ACK, ZERO, EXEC_DONE,
    input MEM_REQ, MEM_ADDR, IR_ADDR, LOAD, PC_STEP, IR_OUT, EXEC_VALID, HALTED
  );
endinterface

// File: rtl/instr_fetch_unit_ir_decode.sv
// ir_decode: combinational opcode classifier
//   opcode  in   instruction opcode field
//   zero    in   datapath zero flag
//   is_halt out  HALT opcode
//   is_ctrl out  JMP or JZ (goes straight to the step state)
//   taken   out  counter should load the jump target
module ir_decode
  import instr_fetch_unit_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           is_halt,
  output logic           is_ctrl,
  output logic           taken
);
  assign is_halt = opcode == OP_HALT;
  assign is_ctrl = opcode == OP_JMP || opcode == OP_JZ;
  assign taken = opcode == OP_JMP || (opcode == OP_JZ && zero);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch/decode sequencer driving memory reads, counter steps and datapath hand-off
//   CLOCK  in  rising-edge clock
//   RST    in  synchronous active-low reset
//   bus    master modport of instr_fetch_unit_if (memory, counter and datapath signals)
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input logic CLOCK,
  input logic RST,
  instr_fetch_unit_if.master bus
);
  state_t state, next;
  logic is_halt, is_ctrl, taken, ack, jump;
  ir_decode u_dec (
    .opcode (opcode_of(bus.IR_OUT)),
    .zero   (bus.ZERO),
    .is_halt(is_halt),
    .is_ctrl(is_ctrl),
    .taken  (taken)
  );
  // An ACK counts only while a request is actually presented, so one arriving
  // on the edge that leaves reset is ignored.
  assign ack = state == S_FETCH && bus.MEM_REQ && bus.MEM_ACK;
  assign jump = state == S_DECODE && is_ctrl && taken;
  always_comb begin
    next = state;
    case (state)
      S_FETCH:  next = ack ? S_DECODE : S_FETCH;
      S_DECODE: next = is_halt ? S_HALT : is_ctrl ? S_STEP : S_EXEC;
      S_EXEC:   next = bus.EXEC_DONE ? S_STEP : S_EXEC;
      S_STEP:   next = S_FETCH;
      default:  next = S_HALT;
    endcase
  end
  always_ff @(posedge CLOCK)
    if (!RST) state <= S_FETCH;
    else state <= next;
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge CLOCK)
    if (!RST) begin
      bus.MEM_REQ <= 1'b0;
      bus.MEM_ADDR <= '0;
      bus.IR_ADDR <= '0;
      bus.LOAD <= 1'b0;
      bus.PC_STEP <= 1'b0;
      bus.IR_OUT <= '0;
      bus.EXEC_VALID <= 1'b0;
      bus.HALTED <= 1'b0;
    end else begin
      bus.MEM_REQ <= next == S_FETCH;
      // MEM_REQ low marks the edge that starts a request: latch the address once and hold it.
      if (next == S_FETCH && !bus.MEM_REQ) bus.MEM_ADDR <= bus.PC_ADDR;
      if (ack) bus.IR_OUT <= bus.MEM_RDATA;
      if (jump) bus.IR_ADDR <= bus.IR_OUT[AW-1:0];
      bus.LOAD <= jump;
      bus.PC_STEP <= next == S_STEP;
      bus.EXEC_VALID <= next == S_EXEC;
      bus.HALTED <= next == S_HALT;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed table-driven bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;
  logic CLOCK = 1'b0;
  logic RST = 1'b0;
  instr_fetch_unit_if bus ();
  instr_fetch_unit dut (
    .CLOCK(CLOCK),
    .RST  (RST),
    .bus  (bus)
  );
  always #5 CLOCK = ~CLOCK;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] rdata;
    logic zero;
    int waits;
    int n_exec;
    logic exp_load;
    logic [AW-1:0] exp_ir_addr;
    int exp_step;
  } vec_t;
  vec_t v[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(negedge CLOCK);
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_mem_req"}, bus.MEM_REQ, 0);
    chk({tag, "_mem_addr"}, bus.MEM_ADDR, 0);
    chk({tag, "_ir_addr"}, bus.IR_ADDR, 0);
    chk({tag, "_load"}, bus.LOAD, 0);
    chk({tag, "_pc_step"}, bus.PC_STEP, 0);
    chk({tag, "_ir_out"}, bus.IR_OUT, 0);
    chk({tag, "_exec_valid"}, bus.EXEC_VALID, 0);
    chk({tag, "_halted"}, bus.HALTED, 0);
  endtask
  // Starts at the falling edge of the first MEM_REQ cycle of an instruction and
  // ends at the falling edge of the first MEM_REQ cycle of the next one.
  task automatic run(input vec_t t, input logic [IW-1:0] prev_ir, input logic [AW-1:0] next_pc);
    int cyc;
    int ev;
    bit seen;
    cyc = 1;
    chk("req_on", bus.MEM_REQ, 1);
    for (int w = 0; w < t.waits; w++) begin
      chk("wait_addr", bus.MEM_ADDR, t.pc);
      chk("wait_req", bus.MEM_REQ, 1);
      chk("wait_ir", bus.IR_OUT, prev_ir);
      bus.MEM_ACK = 1'b0;
      bus.MEM_RDATA = ~t.rdata;
      tick;
      cyc++;
    end
    chk("fetch_addr", bus.MEM_ADDR, t.pc);
    bus.MEM_ACK = 1'b1;
    bus.MEM_RDATA = t.rdata;
    bus.ZERO = t.zero;
    tick;
    cyc++;
    bus.MEM_ACK = 1'b0;
    bus.MEM_RDATA = '0;
    chk("ir", bus.IR_OUT, t.rdata);
    chk("decode_req", bus.MEM_REQ, 0);
    ev = 0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick;
      cyc++;
      bus.EXEC_DONE = 1'b0;
      if (bus.PC_STEP) seen = 1;
      else if (bus.EXEC_VALID) begin
        ev++;
        chk("exec_req", bus.MEM_REQ, 0);
        if (ev == t.n_exec) bus.EXEC_DONE = 1'b1;
      end
    end
    chk("step_seen", seen, 1);
    chk("step_cycle", cyc, t.exp_step);
    chk("exec_len", ev, t.n_exec);
    chk("load", bus.LOAD, t.exp_load);
    chk("ir_addr", bus.IR_ADDR, t.exp_ir_addr);
    chk("step_req", bus.MEM_REQ, 0);
    bus.PC_ADDR = next_pc;
    bus.ZERO = 1'b0;
    tick;
    chk("refetch_req", bus.MEM_REQ, 1);
    chk("step_pulse", bus.PC_STEP, 0);
  endtask
  initial begin
    v[0] = '{13'h0000, 16'h3ABC, 1'b0, 0, 0, 1'b1, 13'h1ABC, 3};
    v[1] = '{13'h0123, 16'h4005, 1'b0, 0, 0, 1'b0, 13'h1ABC, 3};
    v[2] = '{13'h0124, 16'h4005, 1'b1, 0, 0, 1'b1, 13'h0005, 3};
    v[3] = '{13'h0200, 16'h6001, 1'b0, 0, 4, 1'b0, 13'h0005, 7};
    v[4] = '{13'h1FFF, 16'h7FFF, 1'b1, 5, 1, 1'b0, 13'h0005, 9};
    v[5] = '{13'h0010, 16'h2000, 1'b0, 2, 0, 1'b1, 13'h0000, 5};
    v[6] = '{13'h0AAA, 16'h5555, 1'b1, 0, 0, 1'b1, 13'h1555, 3};
    v[7] = '{13'h1000, 16'hE123, 1'b1, 0, 2, 1'b0, 13'h1555, 5};
    bus.PC_ADDR = v[0].pc;
    bus.MEM_RDATA = '0;
    bus.MEM_ACK = 1'b0;
    bus.ZERO = 1'b0;
    bus.EXEC_DONE = 1'b0;
    RST = 1'b0;
    repeat (2) @(posedge CLOCK);
    tick;
    chk_idle("reset");
    RST = 1'b1;
    tick;
    chk("reset_exit_req", bus.MEM_REQ, 1);
    for (int i = 0; i < 8; i++)
      run(v[i], i == 0 ? 16'h0000 : v[i-1].rdata, i == 7 ? 13'h0ABC : v[i+1].pc);
    chk("midexec_addr", bus.MEM_ADDR, 13'h0ABC);
    bus.MEM_ACK = 1'b1;
    bus.MEM_RDATA = 16'h6001;
    tick;
    bus.MEM_ACK = 1'b0;
    repeat (2) tick;
    chk("midexec_valid", bus.EXEC_VALID, 1);
    RST = 1'b0;
    bus.EXEC_DONE = 1'b1;
    bus.MEM_ACK = 1'b1;
    bus.MEM_RDATA = 16'h3ABC;
    repeat (2) @(posedge CLOCK);
    tick;
    chk_idle("midexec_reset");
    RST = 1'b1;
    tick;
    bus.EXEC_DONE = 1'b0;
    bus.MEM_ACK = 1'b0;
    chk("late_ack_req", bus.MEM_REQ, 1);
    chk("late_done_valid", bus.EXEC_VALID, 0);
    chk("late_ack_ir", bus.IR_OUT, 0);
    tick;
    chk("late_ack_hold", bus.MEM_REQ, 1);
    bus.MEM_ACK = 1'b1;
    bus.MEM_RDATA = 16'h0000;
    tick;
    bus.MEM_ACK = 1'b0;
    chk("halt_decode", bus.HALTED, 0);
    tick;
    chk("halt_set", bus.HALTED, 1);
    bus.MEM_ACK = 1'b1;
    bus.EXEC_DONE = 1'b1;
    bus.MEM_RDATA = 16'h3ABC;
    bus.ZERO = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("halt_sticky", bus.HALTED, 1);
      chk("halt_no_step", bus.PC_STEP, 0);
      chk("halt_no_req", bus.MEM_REQ, 0);
      chk("halt_no_exec", bus.EXEC_VALID, 0);
      chk("halt_ir", bus.IR_OUT, 0);
    end
    bus.MEM_ACK = 1'b0;
    bus.EXEC_DONE = 1'b0;
    RST = 1'b0;
    tick;
    chk("halt_reset", bus.HALTED, 0);
    RST = 1'b1;
    tick;
    chk("halt_refetch", bus.MEM_REQ, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
